// File: rtl/syn_fft_pkg.sv
// syn_fft_pkg: shared types and constants for the fgyrus FFT engine
package syn_fft_pkg;
    typedef enum logic {NORMAL, CONFIG} fgyrus_mode_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_seq_state_t;
    localparam int P_FFT_NUM_SAMPLES = 128;
    localparam int P_FFT_BFLY_LAT = 4;
endpackage

// File: rtl/syn_fft_addr_dly.sv
// syn_fft_addr_dly: valid-plus-data shift register of fixed depth
module syn_fft_addr_dly #(
    parameter int P_DEPTH = 4,
    parameter int P_W = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    input  logic [P_W-1:0] dat,
    output logic           dly_vld,
    output logic [P_W-1:0] dly_dat
);
    logic [P_DEPTH-1:0] vld_sr;
    logic [P_W-1:0]     dat_sr [P_DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < P_DEPTH; i++) dat_sr[i] <= '0;
        end else begin
            vld_sr[0] <= vld;
            dat_sr[0] <= dat;
            for (int i = 1; i < P_DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                dat_sr[i] <= dat_sr[i-1];
            end
        end
    end
    assign dly_vld = vld_sr[P_DEPTH-1];
    assign dly_dat = dat_sr[P_DEPTH-1];
endmodule

// File: rtl/syn_fft_seq_ctrl.sv
// syn_fft_seq_ctrl: stage/butterfly address sequencer for the in-place radix-2 DIT FFT
module syn_fft_seq_ctrl
    import syn_fft_pkg::*;
#(
    parameter int P_NUM_SAMPLES = P_FFT_NUM_SAMPLES,
    parameter int P_LOG2_N      = $clog2(P_NUM_SAMPLES),
    parameter int P_BFLY_LAT    = P_FFT_BFLY_LAT,
    parameter int P_RAM_ADDR_W  = P_LOG2_N,
    parameter int P_TWDL_ADDR_W = P_LOG2_N - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  fgyrus_mode_t             fgyrus_mode_i,
    input  logic                     fft_start_i,
    output logic                     fft_busy_o,
    output logic                     fft_done_o,
    output logic [P_LOG2_N-1:0]      fft_stage_o,
    output logic                     rd_en_o,
    output logic [P_RAM_ADDR_W-1:0]  rd_addr_a_o,
    output logic [P_RAM_ADDR_W-1:0]  rd_addr_b_o,
    output logic [P_TWDL_ADDR_W-1:0] twdl_addr_o,
    output logic                     wr_en_o,
    output logic [P_RAM_ADDR_W-1:0]  wr_addr_a_o,
    output logic [P_RAM_ADDR_W-1:0]  wr_addr_b_o
);
    localparam int BW = P_LOG2_N - 1;
    localparam int DW = $clog2(P_BFLY_LAT) + 1;
    fft_seq_state_t           state;
    logic [BW-1:0]            bfly;
    logic [DW-1:0]            dcnt;
    logic                     last_bfly, last_drain, last_stage, issue;
    logic [P_LOG2_N-1:0]      iss_s;
    logic [P_RAM_ADDR_W-1:0]  iss_b, pos, grp, iss_a;
    logic [P_TWDL_ADDR_W-1:0] iss_t;
    logic                     dly_vld;
    logic [2*P_RAM_ADDR_W-1:0] dly_dat;
    // iss_* describe the butterfly whose read is presented in the next cycle
    always_comb begin
        last_bfly  = &bfly;
        last_drain = dcnt == DW'(P_BFLY_LAT - 1);
        last_stage = fft_stage_o == P_LOG2_N'(P_LOG2_N - 1);
        issue = (state == IDLE && fft_start_i && fgyrus_mode_i == NORMAL) ||
                (state == RUN && !last_bfly) ||
                (state == DRAIN && last_drain && !last_stage);
        iss_s = state == DRAIN ? fft_stage_o + P_LOG2_N'(1) : (state == RUN ? fft_stage_o : '0);
        iss_b = state == RUN ? P_RAM_ADDR_W'(bfly) + P_RAM_ADDR_W'(1) : '0;
        pos   = iss_b & ((P_RAM_ADDR_W'(1) << iss_s) - P_RAM_ADDR_W'(1));
        grp   = iss_b >> iss_s;
        iss_a = (grp << (iss_s + P_LOG2_N'(1))) | pos;
        iss_t = P_TWDL_ADDR_W'(pos << (P_LOG2_N'(P_LOG2_N - 1) - iss_s));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bfly        <= '0;
            dcnt        <= '0;
            fft_stage_o <= '0;
            fft_busy_o  <= 1'b0;
            fft_done_o  <= 1'b0;
            rd_en_o     <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            twdl_addr_o <= '0;
        end else begin
            rd_en_o     <= issue;
            rd_addr_a_o <= issue ? iss_a : '0;
            rd_addr_b_o <= issue ? iss_a + (P_RAM_ADDR_W'(1) << iss_s) : '0;
            twdl_addr_o <= issue ? iss_t : '0;
            fft_done_o  <= state == DRAIN && last_drain && last_stage;
            case (state)
                IDLE: if (issue) begin
                    state       <= RUN;
                    bfly        <= '0;
                    fft_stage_o <= '0;
                    fft_busy_o  <= 1'b1;
                end
                RUN: if (last_bfly) begin
                    state <= DRAIN;
                    dcnt  <= '0;
                end else
                    bfly <= bfly + BW'(1);
                DRAIN: if (!last_drain)
                    dcnt <= dcnt + DW'(1);
                else if (last_stage) begin
                    state       <= DONE;
                    fft_busy_o  <= 1'b0;
                    fft_stage_o <= '0;
                end else begin
                    state       <= RUN;
                    bfly        <= '0;
                    fft_stage_o <= iss_s;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
    syn_fft_addr_dly #(.P_DEPTH(P_BFLY_LAT), .P_W(2*P_RAM_ADDR_W)) u_wr_dly (
        .clk     (clk),
        .rst     (rst),
        .vld     (rd_en_o),
        .dat     ({rd_addr_a_o, rd_addr_b_o}),
        .dly_vld (dly_vld),
        .dly_dat (dly_dat)
    );
    assign wr_en_o = dly_vld & ~rst;
    assign {wr_addr_a_o, wr_addr_b_o} = dly_dat;
endmodule

// File: tb/tb_syn_fft_seq_ctrl.sv
// tb_syn_fft_seq_ctrl: table, directed and randomized checks of the FFT sequencer at N=8 and N=128
module tb_syn_fft_seq_ctrl;
    import syn_fft_pkg::*;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    fgyrus_mode_t mode = NORMAL;
    always #5 clk = ~clk;
    logic s_busy, s_done, s_rd, s_wr;
    logic [2:0] s_stage, s_ra, s_rb, s_wa, s_wb;
    logic [1:0] s_tw;
    logic b_busy, b_done, b_rd, b_wr;
    logic [6:0] b_stage, b_ra, b_rb, b_wa, b_wb;
    logic [5:0] b_tw;
    syn_fft_seq_ctrl #(.P_NUM_SAMPLES(8), .P_LOG2_N(3), .P_BFLY_LAT(2), .P_RAM_ADDR_W(3), .P_TWDL_ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .fgyrus_mode_i(mode), .fft_start_i(start),
        .fft_busy_o(s_busy), .fft_done_o(s_done), .fft_stage_o(s_stage),
        .rd_en_o(s_rd), .rd_addr_a_o(s_ra), .rd_addr_b_o(s_rb), .twdl_addr_o(s_tw),
        .wr_en_o(s_wr), .wr_addr_a_o(s_wa), .wr_addr_b_o(s_wb));
    syn_fft_seq_ctrl u_big (
        .clk(clk), .rst(rst), .fgyrus_mode_i(mode), .fft_start_i(start),
        .fft_busy_o(b_busy), .fft_done_o(b_done), .fft_stage_o(b_stage),
        .rd_en_o(b_rd), .rd_addr_a_o(b_ra), .rd_addr_b_o(b_rb), .twdl_addr_o(b_tw),
        .wr_en_o(b_wr), .wr_addr_a_o(b_wa), .wr_addr_b_o(b_wb));
    typedef struct {
        logic busy, done;
        int   stage;
        logic rd;
        int   ra, rb, tw;
        logic wr;
        int   wa, wb;
    } exp_t;
    typedef struct {
        logic start;
        exp_t e;
    } row_t;
    row_t tbl [21];
    int checks = 0, failures = 0;
    int mn [2] = '{8, 128};
    int mlat [2] = '{2, 4};
    int mlg [2] = '{3, 7};
    int m_act [2] = '{0, 0};
    int m_k [2] = '{0, 0};
    int rcnt, wcnt, wmap [7][128];
    function automatic void leg(input int n, input int s, input int b, output int a, output int bb, output int tw);
        int h;
        h  = 2 ** s;
        a  = (b / h) * 2 * h + b % h;
        bb = a + h;
        tw = (b % h) * (n / (2 * h));
    endfunction
    // expected outputs k cycles after an accepted start, derived from cycle arithmetic alone
    function automatic exp_t model(input int n, input int lat, input int lg, input int act, input int k);
        exp_t e;
        int p, s, w, d;
        e = '{default: 0};
        p = n / 2 + lat;
        if (act != 0) begin
            e.busy = k <= lg * p;
            e.done = k == lg * p + 1;
            if (e.busy) begin
                s = (k - 1) / p;
                w = (k - 1) % p;
                e.stage = s;
                if (w < n / 2) begin
                    e.rd = 1'b1;
                    leg(n, s, w, e.ra, e.rb, e.tw);
                end
            end
            if (k - lat >= 1 && k - lat <= lg * p) begin
                s = (k - lat - 1) / p;
                w = (k - lat - 1) % p;
                if (w < n / 2) begin
                    e.wr = 1'b1;
                    leg(n, s, w, e.wa, e.wb, d);
                end
            end
        end
        return e;
    endfunction
    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic cmp(input string tag, input exp_t e, input int busy, input int done, input int stage,
                       input int rd, input int ra, input int rb, input int tw, input int wr, input int wa, input int wb);
        chk({tag, ".busy"}, busy, int'(e.busy));
        chk({tag, ".done"}, done, int'(e.done));
        if (!e.done) chk({tag, ".stage"}, stage, e.stage);
        chk({tag, ".rd_en"}, rd, int'(e.rd));
        chk({tag, ".rd_a"}, ra, e.ra);
        chk({tag, ".rd_b"}, rb, e.rb);
        chk({tag, ".twdl"}, tw, e.tw);
        chk({tag, ".wr_en"}, wr, int'(e.wr));
        chk({tag, ".wr_a"}, wa, e.wa);
        chk({tag, ".wr_b"}, wb, e.wb);
    endtask
    task automatic cmp_small(input string tag, input exp_t e);
        cmp(tag, e, int'(s_busy), int'(s_done), int'(s_stage), int'(s_rd), int'(s_ra), int'(s_rb),
            int'(s_tw), int'(s_wr), int'(s_wa), int'(s_wb));
    endtask
    task automatic cmp_big(input string tag, input exp_t e);
        cmp(tag, e, int'(b_busy), int'(b_done), int'(b_stage), int'(b_rd), int'(b_ra), int'(b_rb),
            int'(b_tw), int'(b_wr), int'(b_wa), int'(b_wb));
    endtask
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 0;
                m_k[i] = 0;
            end else if (m_act[i] != 0) begin
                if (m_k[i] == mlg[i] * (mn[i] / 2 + mlat[i]) + 1) m_act[i] = 0;
                else m_k[i]++;
            end else if (start && mode == NORMAL) begin
                m_act[i] = 1;
                m_k[i] = 1;
            end
        end
        @(negedge clk);
        cmp_small("mdl8", model(mn[0], mlat[0], mlg[0], m_act[0], m_k[0]));
        cmp_big("mdl128", model(mn[1], mlat[1], mlg[1], m_act[1], m_k[1]));
        if (b_rd) rcnt++;
        if (b_wr) begin
            wcnt++;
            if (b_stage < 7) begin
                wmap[b_stage][b_wa]++;
                wmap[b_stage][b_wb]++;
            end
        end
    endtask
    task automatic run_table(input int extra, input int cfg_from);
        for (int c = 0; c < 21; c++) begin
            start = tbl[c].start | (c == extra);
            mode = (c >= cfg_from) ? CONFIG : NORMAL;
            cmp_small($sformatf("tbl%0d", c), tbl[c].e);
            tick();
        end
        start = 1'b0;
        mode = NORMAL;
    endtask
    initial begin
        exp_t z;
        int c, ones;
        z = '{default: 0};
        tbl = '{
            '{1'b1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}},
            '{1'b0, '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0}},
            '{1'b0, '{1, 0, 0, 1, 2, 3, 0, 0, 0, 0}},
            '{1'b0, '{1, 0, 0, 1, 4, 5, 0, 1, 0, 1}},
            '{1'b0, '{1, 0, 0, 1, 6, 7, 0, 1, 2, 3}},
            '{1'b0, '{1, 0, 0, 0, 0, 0, 0, 1, 4, 5}},
            '{1'b0, '{1, 0, 0, 0, 0, 0, 0, 1, 6, 7}},
            '{1'b0, '{1, 0, 1, 1, 0, 2, 0, 0, 0, 0}},
            '{1'b0, '{1, 0, 1, 1, 1, 3, 2, 0, 0, 0}},
            '{1'b0, '{1, 0, 1, 1, 4, 6, 0, 1, 0, 2}},
            '{1'b0, '{1, 0, 1, 1, 5, 7, 2, 1, 1, 3}},
            '{1'b0, '{1, 0, 1, 0, 0, 0, 0, 1, 4, 6}},
            '{1'b0, '{1, 0, 1, 0, 0, 0, 0, 1, 5, 7}},
            '{1'b0, '{1, 0, 2, 1, 0, 4, 0, 0, 0, 0}},
            '{1'b0, '{1, 0, 2, 1, 1, 5, 1, 0, 0, 0}},
            '{1'b0, '{1, 0, 2, 1, 2, 6, 2, 1, 0, 4}},
            '{1'b0, '{1, 0, 2, 1, 3, 7, 3, 1, 1, 5}},
            '{1'b0, '{1, 0, 2, 0, 0, 0, 0, 1, 2, 6}},
            '{1'b0, '{1, 0, 2, 0, 0, 0, 0, 1, 3, 7}},
            '{1'b0, '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0}},
            '{1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}}
        };
        repeat (3) tick();
        cmp_small("reset8", z);
        cmp_big("reset128", z);
        rst = 1'b0;
        tick();
        run_table(-1, 99);
        mode = CONFIG;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("cfg_start.busy", int'(s_busy), 0);
        chk("cfg_start.rd_en", int'(s_rd), 0);
        mode = NORMAL;
        run_table(-1, 99);
        run_table(5, 99);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        cmp_small("rst_mid", z);
        rst = 1'b0;
        tick();
        run_table(-1, 99);
        run_table(-1, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rcnt = 0;
        wcnt = 0;
        foreach (wmap[s, a]) wmap[s][a] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (!b_done && c < 600) begin
            tick();
            c++;
        end
        chk("big.done_cycle", c, 477);
        chk("big.reads", rcnt, 448);
        chk("big.writes", wcnt, 448);
        for (int s = 0; s < 7; s++) begin
            ones = 0;
            for (int a = 0; a < 128; a++) if (wmap[s][a] == 1) ones++;
            chk($sformatf("big.stage%0d_written_once", s), ones, 128);
        end
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 1499) == 0;
            start = $urandom_range(0, 15) == 0;
            mode = ($urandom_range(0, 3) == 0) ? CONFIG : NORMAL;
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
